// File: rtl/vram_wb_responder.sv
// Frame-buffer VRAM with two Wishbone slave ports (CPU and display fetch)
// sharing one single-port 32-bit RAM through a round-robin arbiter.
module vram_wb_responder #(
    parameter int          ADDR_BITS = 13,
    parameter logic [31:0] BASE_ADDR = 32'h4080_0000
) (
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic [31:0] a_adr_i,
    input  logic [31:0] a_dat_i,
    input  logic [3:0]  a_sel_i,
    input  logic        a_cyc_i,
    input  logic        a_stb_i,
    input  logic        a_we_i,
    output logic [31:0] a_dat_o,
    output logic        a_ack_o,
    input  logic [31:0] b_adr_i,
    input  logic [31:0] b_dat_i,
    input  logic [3:0]  b_sel_i,
    input  logic        b_cyc_i,
    input  logic        b_stb_i,
    input  logic        b_we_i,
    output logic [31:0] b_dat_o,
    output logic        b_ack_o
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t state, state_nx;

    logic [31:0]          mem [DEPTH];
    logic                 req_a, req_b, pick_b;
    logic                 hit_a, hit_b;
    logic                 gnt_b, last_b;
    logic [ADDR_BITS-1:0] idx;
    logic                 we_r, hit_r;
    logic [3:0]           sel_r;
    logic [31:0]          wdat;
    logic [31:0]          rdata;
    logic                 unused_bits;

    assign req_a = a_cyc_i & a_stb_i;
    assign req_b = b_cyc_i & b_stb_i;
    assign hit_a = a_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
    assign hit_b = b_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
    assign unused_bits = ^{a_adr_i[1:0], b_adr_i[1:0]};

    // On a tie the port that did not win last time is served.
    assign pick_b = req_b & (~req_a | ~last_b);

    assign rdata = hit_r ? mem[idx] : 32'h0;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_a | req_b) state_nx = ACCESS;
            ACCESS:  state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            gnt_b  <= 1'b0;
            last_b <= 1'b0;
            idx    <= '0;
            we_r   <= 1'b0;
            hit_r  <= 1'b0;
            sel_r  <= 4'h0;
            wdat   <= 32'h0;
        end else if (state == IDLE && (req_a | req_b)) begin
            gnt_b  <= pick_b;
            last_b <= pick_b;
            idx    <= pick_b ? b_adr_i[ADDR_BITS+1:2] : a_adr_i[ADDR_BITS+1:2];
            we_r   <= pick_b ? b_we_i : a_we_i;
            hit_r  <= pick_b ? hit_b : hit_a;
            sel_r  <= pick_b ? b_sel_i : a_sel_i;
            wdat   <= pick_b ? b_dat_i : a_dat_i;
        end
    end

    // Ack and read data only for a master that still holds its cycle.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            a_ack_o <= 1'b0;
            b_ack_o <= 1'b0;
            a_dat_o <= 32'h0;
            b_dat_o <= 32'h0;
        end else begin
            a_ack_o <= 1'b0;
            b_ack_o <= 1'b0;
            if (state == ACCESS) begin
                if (!gnt_b && a_cyc_i) begin
                    a_ack_o <= 1'b1;
                    if (!we_r) a_dat_o <= rdata;
                end
                if (gnt_b && b_cyc_i) begin
                    b_ack_o <= 1'b1;
                    if (!we_r) b_dat_o <= rdata;
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (state == ACCESS && hit_r && we_r) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_r[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_vram_wb_responder.sv
// Bench for vram_wb_responder: per-port scoreboard queues filled at issue
// from a word-array model, drained by a negedge monitor on every ack.
module tb_vram_wb_responder;
    localparam logic [31:0] BASE = 32'h4080_0000;
    localparam logic [31:0] MISS = 32'h4081_0000;

    logic        clk_100MHz = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_adr_i = '0, a_dat_i = '0, b_adr_i = '0, b_dat_i = '0;
    logic [3:0]  a_sel_i = '0, b_sel_i = '0;
    logic        a_cyc_i = 0, a_stb_i = 0, a_we_i = 0;
    logic        b_cyc_i = 0, b_stb_i = 0, b_we_i = 0;
    logic [31:0] a_dat_o, b_dat_o;
    logic        a_ack_o, b_ack_o;

    always #5 clk_100MHz = ~clk_100MHz;

    vram_wb_responder dut (
        .clk_100MHz(clk_100MHz), .rst(rst),
        .a_adr_i(a_adr_i), .a_dat_i(a_dat_i), .a_sel_i(a_sel_i),
        .a_cyc_i(a_cyc_i), .a_stb_i(a_stb_i), .a_we_i(a_we_i),
        .a_dat_o(a_dat_o), .a_ack_o(a_ack_o),
        .b_adr_i(b_adr_i), .b_dat_i(b_dat_i), .b_sel_i(b_sel_i),
        .b_cyc_i(b_cyc_i), .b_stb_i(b_stb_i), .b_we_i(b_we_i),
        .b_dat_o(b_dat_o), .b_ack_o(b_ack_o)
    );

    logic [31:0] mem_m [8192];
    logic [31:0] last_rd [2];
    logic [31:0] expq_a [$];
    logic [31:0] expq_b [$];
    int          tests = 0;
    int          fails = 0;
    logic        prev_a = 0, prev_b = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] adr);
        return adr[31:15] == BASE[31:15];
    endfunction

    // Reference: a plain word array; a read of a missed window returns zero.
    task automatic model(input bit p, input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input bit push);
        int i;
        i = int'(adr[14:2]);
        if (we) begin
            if (in_win(adr))
                for (int l = 0; l < 4; l++)
                    if (sel[l]) mem_m[i][8*l +: 8] = dat[8*l +: 8];
        end else begin
            last_rd[p] = in_win(adr) ? mem_m[i] : 32'h0;
        end
        if (push) begin
            if (p) expq_b.push_back(last_rd[1]);
            else   expq_a.push_back(last_rd[0]);
        end
    endtask

    task automatic drive(input bit p, input bit on, input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (p) begin
            b_cyc_i = on; b_stb_i = on; b_we_i = we;
            b_adr_i = adr; b_dat_i = dat; b_sel_i = sel;
        end else begin
            a_cyc_i = on; a_stb_i = on; a_we_i = we;
            a_adr_i = adr; a_dat_i = dat; a_sel_i = sel;
        end
    endtask

    // Called just after a rising edge; lat counts negedges until ack is seen
    // (3 when uncontended: idle, access, ack cycles).
    task automatic xfer(input bit p, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input bit hold, output int lat);
        logic ack;
        model(p, we, adr, dat, sel, 1'b1);
        drive(p, 1'b1, we, adr, dat, sel);
        lat = 0;
        do begin
            @(negedge clk_100MHz);
            lat++;
            ack = p ? b_ack_o : a_ack_o;
        end while (!ack && lat < 40);
        if (!ack) begin
            tests++; fails++;
            $display("FAIL ack_timeout port %0d: got no ack want ack within 40", p);
        end
        @(posedge clk_100MHz); #1;
        if (!hold) drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic mon(input bit p, input logic ack, input logic prev,
                       input logic [31:0] dat, input logic other);
        logic [31:0] e;
        if (!ack) return;
        chk(p ? "b_ack_excl" : "a_ack_excl", {31'h0, other}, 32'h0);
        tests++;
        if (prev) begin
            fails++;
            $display("FAIL dup_ack port %0d: got 2-cycle ack want 1-cycle pulse", p);
        end else if ((p ? expq_b.size() : expq_a.size()) == 0) begin
            fails++;
            $display("FAIL unexpected_ack port %0d: got ack want none", p);
        end else begin
            e = p ? expq_b.pop_front() : expq_a.pop_front();
            if (dat !== e) begin
                fails++;
                $display("FAIL rd_data port %0d: got %h want %h", p, dat, e);
            end
        end
    endtask

    always @(negedge clk_100MHz) begin
        if (rst) begin
            prev_a = 0;
            prev_b = 0;
        end else begin
            mon(1'b0, a_ack_o, prev_a, a_dat_o, b_ack_o);
            mon(1'b1, b_ack_o, prev_b, b_dat_o, a_ack_o);
            prev_a = a_ack_o;
            prev_b = b_ack_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat_a, lat_b;
        logic seen;
        last_rd[0] = 0;
        last_rd[1] = 0;
        repeat (3) @(posedge clk_100MHz);
        #1;
        chk("rst_a_ack", {31'h0, a_ack_o}, 32'h0);
        chk("rst_b_ack", {31'h0, b_ack_o}, 32'h0);
        chk("rst_a_dat", a_dat_o, 32'h0);
        chk("rst_b_dat", b_dat_o, 32'h0);
        #2 rst = 0;
        @(posedge clk_100MHz); #1;

        for (int i = 0; i < 32; i++)
            xfer(1'b0, 1'b1, BASE + 32'(i * 4), $urandom, 4'hF, 1'b0, lat);

        xfer(1'b0, 1'b1, 32'h4080_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, lat);
        xfer(1'b1, 1'b0, 32'h4080_0010, 32'h0, 4'hF, 1'b0, lat);
        chk("b_read_lat", lat, 3);
        chk("b_read_dat", b_dat_o, 32'hDEAD_BEEF);

        xfer(1'b0, 1'b1, 32'h4080_0020, 32'h1122_3344, 4'hF, 1'b0, lat);
        xfer(1'b0, 1'b1, 32'h4080_0020, 32'hAABB_CCDD, 4'b0101, 1'b0, lat);
        xfer(1'b0, 1'b0, 32'h4080_0020, 32'h0, 4'h0, 1'b0, lat);
        chk("byte_lanes", a_dat_o, 32'h11BB_33DD);

        for (int r = 0; r < 2; r++) begin
            fork
                xfer(1'b0, 1'b0, 32'h4080_0008, 32'h0, 4'hF, 1'b0, lat_a);
                xfer(1'b1, 1'b0, 32'h4080_000C, 32'h0, 4'hF, 1'b0, lat_b);
            join
            chk("tie_b_lat", lat_b, 3);
            chk("tie_a_lat", lat_a, 6);
        end

        xfer(1'b1, 1'b0, 32'h4090_0000, 32'h0, 4'hF, 1'b0, lat);
        chk("miss_lat", lat, 3);
        chk("miss_dat", b_dat_o, 32'h0);
        xfer(1'b0, 1'b1, 32'h4090_0000, 32'hCAFE_F00D, 4'hF, 1'b0, lat);
        xfer(1'b0, 1'b0, 32'h4080_0000, 32'h0, 4'hF, 1'b0, lat);

        model(1'b0, 1'b1, 32'h4080_0040, 32'h0BAD_F00D, 4'hF, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h4080_0040, 32'h0BAD_F00D, 4'hF);
        @(posedge clk_100MHz); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        seen = 0;
        repeat (4) begin
            @(negedge clk_100MHz);
            seen = seen | a_ack_o;
        end
        chk("abort_no_ack", {31'h0, seen}, 32'h0);
        @(posedge clk_100MHz); #1;
        xfer(1'b0, 1'b0, 32'h4080_0040, 32'h0, 4'hF, 1'b0, lat);

        drive(1'b0, 1'b1, 1'b1, 32'h4080_0010, 32'h5555_5555, 4'hF);
        @(posedge clk_100MHz);
        #2 rst = 1;
        #1;
        chk("rst_mid_a_ack", {31'h0, a_ack_o}, 32'h0);
        chk("rst_mid_a_dat", a_dat_o, 32'h0);
        chk("rst_mid_b_dat", b_dat_o, 32'h0);
        last_rd[0] = 0;
        last_rd[1] = 0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk_100MHz);
        #3 rst = 0;
        @(posedge clk_100MHz); #1;
        xfer(1'b1, 1'b0, 32'h4080_0010, 32'h0, 4'hF, 1'b0, lat);
        chk("rst_lost_write", b_dat_o, 32'hDEAD_BEEF);

        for (int i = 0; i < 16; i++) begin
            xfer(1'b1, 1'b0, BASE + 32'(i * 4), 32'h0, 4'hF, i < 15, lat);
            chk("b2b_spacing", lat, 3);
        end

        fork
            begin
                int la;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk_100MHz); #1;
                    end
                    xfer(1'b0, 1'($urandom_range(0, 1)),
                         (($urandom_range(0, 7) == 0) ? MISS : BASE) |
                         32'($urandom_range(0, 15) * 8),
                         $urandom, 4'($urandom_range(0, 15)), 1'b0, la);
                end
            end
            begin
                int lb;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk_100MHz); #1;
                    end
                    xfer(1'b1, 1'($urandom_range(0, 1)),
                         (($urandom_range(0, 7) == 0) ? MISS : BASE) |
                         32'($urandom_range(0, 15) * 8 + 4),
                         $urandom, 4'($urandom_range(0, 15)), 1'b0, lb);
                end
            end
        join

        repeat (5) @(posedge clk_100MHz);
        #1;
        chk("drain_a", 32'(expq_a.size()), 32'h0);
        chk("drain_b", 32'(expq_b.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vram_wb_responder.md
Name: vram_wb_responder

Overview:
- Video RAM block: Wishbone responder that holds the frame buffer the graphic card's display fetch master reads.
- Two slave ports. Port A serves the CPU/system bus, for frame-buffer writes and readback. Port B serves the graphic card's monitor master, read-mostly.
- One internal single-port synchronous RAM of 32-bit words, shared by a round-robin arbiter.
- Sits on the system Wishbone interconnect at the address window the card's map_address defaults to.

Parameters:
- ADDR_BITS, 13, word-address width; RAM depth 2^ADDR_BITS words (default 8192 x 32 = 32 KB).
- BASE_ADDR, 32'h40800000, byte base address of the window; bits [ADDR_BITS+1:0] must be zero.

Ports:
- clk_100MHz  in  1  system clock
- rst  in  1  reset
- a_adr_i  in  32  port A byte address
- a_dat_i  in  32  port A write data
- a_sel_i  in  4  port A byte selects (bit n = byte lane [8n+7:8n])
- a_cyc_i  in  1  port A cycle
- a_stb_i  in  1  port A strobe
- a_we_i  in  1  port A write enable
- a_dat_o  out  32  port A read data
- a_ack_o  out  1  port A acknowledge
- b_adr_i, b_dat_i, b_sel_i, b_cyc_i, b_stb_i, b_we_i, b_dat_o, b_ack_o: same widths and meanings for port B

Interface decision: reset rst, asynchronous, active-high; clock clk_100MHz.

Behaviour:
- Request condition: req_X = X_cyc_i & X_stb_i.
- Window hit: adr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2].
- Word index: adr[ADDR_BITS+1:2]. adr[1:0] is ignored.
- Reset values: a_ack_o=0, b_ack_o=0, a_dat_o=0, b_dat_o=0, state=IDLE, last_grant=A. RAM contents are not reset.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Only one port requesting: grant that port.
  - Both ports requesting: grant the port not in last_grant, so B wins the first tie after reset.
  - On grant: register grant, word index, we, sel, dat_i and hit; update last_grant; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (one cycle):
  - Hit and write: RAM word written at the closing edge, only the byte lanes with sel set; other lanes keep their contents.
  - Hit and read: RAM read at the closing edge; the full 32-bit word is returned regardless of sel.
  - Miss: no RAM access. Read data is 32'h0; writes are discarded.
  - Closing edge: load the granted port's dat_o (read data, or unchanged on write) and set that port's ack_o=1 if its cyc_i is still high; go to ACK.
- ACK (one cycle):
  - Granted ack_o is high for exactly this cycle; dat_o is valid.
  - Closing edge: ack_o returns to 0; go to IDLE.
  - The non-granted port's ack_o stays 0 throughout.
- Latency: request sampled in IDLE at edge N; ack high during the cycle after edge N+1. One access per 3 cycles; no pipelining.
- Ack timing: ack is a single-cycle pulse, never held. The master must drop stb on the edge where it samples ack. A stb still high in IDLE is treated as a new request.
- Abort: if cyc drops during ACCESS, a hit write is still committed, but no ack is issued.
- Ownership: dat_o of each port holds its last value until that port's next read completes.
- Reset mid-operation: FSM returns to IDLE and acks clear immediately (asynchronous). An in-flight write is lost only if reset asserts before the ACCESS closing edge.

Test Plan:
- A writes 32'hDEADBEEF to 0x40800010, sel=4'hF, then B reads 0x40800010 -> b_ack_o pulses 1 cycle, 2 cycles after stb sampled; b_dat_o=32'hDEADBEEF.
- Word holds 32'h11223344; A writes 32'hAABBCCDD with sel=4'b0101; A reads back -> 32'h11BB33DD.
- A and B raise requests on the same edge, first time after reset -> B served first, A acked 3 cycles later. Repeat the tie -> B served first again, since last_grant ends at A.
- B reads 0x40900000 (outside window) -> ack after 2 cycles, dat=0. A writes there, then reads 0x40800000 -> RAM word unchanged.
- Start an A write, assert rst during ACCESS -> a_ack_o=0, state IDLE. After release, B read of the same address completes normally with the old data.
- B issues 16 back-to-back reads of consecutive words -> 16 acks spaced exactly 3 cycles apart; data matches preload; no duplicate acks.
